// File: rtl/cpu_pkg.sv
// cpu_pkg: widths, opcodes, FSM encoding and instruction-field helpers shared by simple_cpu and alu.
package cpu_pkg;
  localparam int ADDR_WIDTH = 6;
  localparam int DATA_WIDTH = 16;
  localparam int OP_LSB = 12;
  localparam int X_LSB = 8;
  localparam int Y_LSB = 4;
  localparam int Z_LSB = 0;
  localparam logic [3:0] OP_MOV = 4'h0;
  localparam logic [3:0] OP_ADD = 4'h1;
  localparam logic [3:0] OP_SUB = 4'h2;
  localparam logic [3:0] OP_MUL = 4'h3;
  localparam logic [3:0] OP_DIV = 4'h4;
  localparam logic [3:0] OP_IN = 4'h7;
  localparam logic [3:0] OP_OUT = 4'h8;
  localparam logic [3:0] OP_STOP = 4'hF;
  typedef enum logic [3:0] {
    S_RESET, S_FETCH, S_FETCH_WAIT, S_LOAD_IR, S_DECODE, S_ADDR, S_WAIT, S_IND,
    S_IND_WAIT, S_LATCH, S_EXEC, S_DEST_WAIT, S_DEST_IND, S_WRITE, S_HALT
  } state_t;
  typedef enum logic [1:0] {SEL_X, SEL_Y, SEL_Z} sel_t;
  function automatic logic [3:0] field(input logic [DATA_WIDTH-1:0] ir, input sel_t s);
    return s == SEL_X ? ir[X_LSB+:4] : s == SEL_Y ? ir[Y_LSB+:4] : ir[Z_LSB+:4];
  endfunction
endpackage

// File: rtl/alu.sv
// alu: combinational MOV/ADD/SUB/MUL/DIV datapath producing a 16-bit result and {N,Z,C,V}.
module alu import cpu_pkg::*; (
  input  logic [2:0]            i_op,
  input  logic [DATA_WIDTH-1:0] i_a,
  input  logic [DATA_WIDTH-1:0] i_b,
  output logic [DATA_WIDTH-1:0] o_result,
  output logic [3:0]            o_flags
);
  logic [DATA_WIDTH:0]     w_sum;
  logic [DATA_WIDTH:0]     w_dif;
  logic [2*DATA_WIDTH-1:0] w_prod;
  logic                    w_c;
  logic                    w_v;
  always_comb begin
    w_sum = {1'b0, i_a} + {1'b0, i_b};
    w_dif = {1'b0, i_a} - {1'b0, i_b};
    w_prod = {{DATA_WIDTH{1'b0}}, i_a} * {{DATA_WIDTH{1'b0}}, i_b};
    o_result = i_op == OP_ADD[2:0] ? w_sum[DATA_WIDTH-1:0] :
               i_op == OP_SUB[2:0] ? w_dif[DATA_WIDTH-1:0] :
               i_op == OP_MUL[2:0] ? w_prod[DATA_WIDTH-1:0] :
               i_op == OP_DIV[2:0] ? (i_b == '0 ? i_a : i_a / i_b) : i_a;
    // C is carry for ADD, borrow for SUB, lost high product bits for MUL
    w_c = i_op == OP_ADD[2:0] ? w_sum[DATA_WIDTH] :
          i_op == OP_SUB[2:0] ? w_dif[DATA_WIDTH] :
          i_op == OP_MUL[2:0] ? |w_prod[2*DATA_WIDTH-1:DATA_WIDTH] : 1'b0;
    w_v = i_op == OP_ADD[2:0] ? (i_a[DATA_WIDTH-1] == i_b[DATA_WIDTH-1]) && (o_result[DATA_WIDTH-1] != i_a[DATA_WIDTH-1]) :
          i_op == OP_SUB[2:0] ? (i_a[DATA_WIDTH-1] != i_b[DATA_WIDTH-1]) && (o_result[DATA_WIDTH-1] != i_a[DATA_WIDTH-1]) : 1'b0;
    o_flags = {o_result[DATA_WIDTH-1], o_result == '0, w_c, w_v};
  end
endmodule

// File: rtl/simple_cpu.sv
// simple_cpu: multicycle 16-bit memory-to-memory CPU; locations 0-7 of the 64-word space serve as registers.
module simple_cpu import cpu_pkg::*; (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic [DATA_WIDTH-1:0] mem,
  input  logic [DATA_WIDTH-1:0] in,
  output logic                  we,
  output logic [ADDR_WIDTH-1:0] addr,
  output logic [DATA_WIDTH-1:0] data,
  output logic [DATA_WIDTH-1:0] out,
  output logic [ADDR_WIDTH-1:0] pc,
  output logic [ADDR_WIDTH-1:0] sp
);
  state_t                r_state, w_state_n;
  sel_t                  r_sel, w_sel_n, w_first;
  logic [ADDR_WIDTH-1:0] r_pc, r_sp, r_addr, w_pc_n, w_addr_n;
  logic [DATA_WIDTH-1:0] r_data, r_ir, r_a, r_b, r_out;
  logic [DATA_WIDTH-1:0] w_data_n, w_ir_n, w_a_n, w_b_n, w_out_n, w_alu, w_res;
  logic [3:0]            r_status, w_st_n, w_flags, w_op, w_fld, w_first_fld;
  logic                  r_we, w_we_n, w_arith, w_wr;
  alu u_alu (.i_op(r_ir[OP_LSB+:3]), .i_a(r_a), .i_b(r_b), .o_result(w_alu), .o_flags(w_flags));
  assign w_op = r_ir[OP_LSB+:4];
  assign w_arith = w_op >= OP_ADD && w_op <= OP_DIV;
  // a divide by zero leaves X untouched, so no write is issued for it
  assign w_wr = (w_op == OP_MOV || w_op == OP_IN || w_arith) && !(w_op == OP_DIV && r_b == '0);
  assign w_res = w_op == OP_IN ? in : w_alu;
  assign w_first = w_op == OP_OUT ? SEL_X : SEL_Y;
  assign w_first_fld = field(r_ir, w_first);
  assign w_fld = field(r_ir, r_sel);
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) r_state <= S_RESET;
    else r_state <= w_state_n;
  always_comb begin
    w_state_n = r_state;
    case (r_state)
      S_RESET: w_state_n = S_FETCH;
      S_FETCH: w_state_n = S_FETCH_WAIT;
      S_FETCH_WAIT: w_state_n = S_LOAD_IR;
      S_LOAD_IR: w_state_n = S_DECODE;
      S_DECODE: w_state_n = w_op == OP_STOP ? S_HALT : w_op == OP_IN ? S_EXEC :
                            (w_op == OP_MOV || w_op == OP_OUT || w_arith) ? S_WAIT : S_FETCH;
      S_ADDR: w_state_n = S_WAIT;
      S_WAIT: w_state_n = w_fld[3] ? S_IND : S_LATCH;
      S_IND: w_state_n = S_IND_WAIT;
      S_IND_WAIT: w_state_n = S_LATCH;
      S_LATCH: w_state_n = (r_sel == SEL_Y && w_arith) ? S_ADDR : S_EXEC;
      S_EXEC: w_state_n = !w_wr ? S_FETCH : r_ir[X_LSB+3] ? S_DEST_WAIT : S_WRITE;
      S_DEST_WAIT: w_state_n = S_DEST_IND;
      S_DEST_IND: w_state_n = S_WRITE;
      S_WRITE: w_state_n = S_FETCH;
      default: w_state_n = S_HALT;
    endcase
  end
  always_comb begin
    w_pc_n = r_pc;
    w_addr_n = r_addr;
    w_data_n = r_data;
    w_we_n = 1'b0;
    w_ir_n = r_ir;
    w_a_n = r_a;
    w_b_n = r_b;
    w_st_n = r_status;
    w_out_n = r_out;
    w_sel_n = r_sel;
    case (r_state)
      S_FETCH: w_addr_n = r_pc;
      S_LOAD_IR: begin
        w_ir_n = mem;
        w_pc_n = r_pc + 1'b1;
      end
      // decode also issues the first source address
      S_DECODE: begin
        w_sel_n = w_first;
        w_addr_n = {3'b0, w_first_fld[2:0]};
      end
      S_ADDR: w_addr_n = {3'b0, w_fld[2:0]};
      S_IND: w_addr_n = mem[ADDR_WIDTH-1:0];
      S_LATCH: begin
        w_a_n = r_sel == SEL_Z ? r_a : mem;
        w_b_n = r_sel == SEL_Z ? mem : r_b;
        w_sel_n = SEL_Z;
      end
      S_EXEC: begin
        w_data_n = w_res;
        w_addr_n = {3'b0, r_ir[X_LSB+:3]};
        w_we_n = w_wr && !r_ir[X_LSB+3];
        w_out_n = w_op == OP_OUT ? r_a : r_out;
        w_st_n = w_arith ? w_flags : r_status;
      end
      S_DEST_IND: begin
        w_addr_n = mem[ADDR_WIDTH-1:0];
        w_we_n = 1'b1;
      end
      default: ;
    endcase
  end
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      r_pc <= 6'd8;
      r_sp <= 6'd63;
      r_addr <= '0;
      r_data <= '0;
      r_we <= 1'b0;
      r_ir <= '0;
      r_a <= '0;
      r_b <= '0;
      r_status <= '0;
      r_out <= '0;
      r_sel <= SEL_Y;
    end else begin
      r_pc <= w_pc_n;
      r_sp <= r_sp;
      r_addr <= w_addr_n;
      r_data <= w_data_n;
      r_we <= w_we_n;
      r_ir <= w_ir_n;
      r_a <= w_a_n;
      r_b <= w_b_n;
      r_status <= w_st_n;
      r_out <= w_out_n;
      r_sel <= w_sel_n;
    end
  assign we = r_we;
  assign addr = r_addr;
  assign data = r_data;
  assign out = r_out;
  assign pc = r_pc;
  assign sp = r_sp;
endmodule

// File: tb/tb_simple_cpu.sv
// tb_simple_cpu: runs a directed program against an instruction-level model, checking every write and out update,
// plus literal end-state, halt and mid-instruction reset checks.
module tb_simple_cpu;
  typedef struct packed {logic [5:0] a; logic [15:0] d;} wr_t;
  logic clk = 1'b0, rst_n = 1'b0, ld = 1'b0, chk = 1'b0;
  logic [15:0] mem_q, data, out_p, prev_out;
  logic [15:0] in_p = 16'h0008;
  logic we;
  logic [5:0] addr, pc, sp, model_pc;
  logic [15:0] m [64];
  logic [15:0] img [64];
  logic [15:0] mm [64];
  wr_t exp_w[$];
  logic [15:0] exp_o[$];
  int ncmp = 0, nfail = 0;

  always #5 clk = ~clk;

  simple_cpu dut (.clk(clk), .rst_n(rst_n), .mem(mem_q), .in(in_p), .we(we), .addr(addr),
                  .data(data), .out(out_p), .pc(pc), .sp(sp));

  always @(posedge clk) begin
    if (ld) m <= img;
    else if (we) m[addr] <= data;
    mem_q <= m[addr];
  end

  task automatic build();
    for (int i = 0; i < 64; i++) img[i] = 16'h0000;
    img[2] = 16'd5; img[4] = 16'h0100; img[6] = 16'd7; img[7] = 16'd20; img[20] = 16'h1234;
    img[8]  = 16'h7000; // IN R0
    img[9]  = 16'h1100; // ADD R1,R0,R0
    img[10] = 16'h8100; // OUT R1
    img[11] = 16'h0A10; // MOV (R2),R1
    img[12] = 16'h4613; // DIV R6,R1,R3 with R3=0
    img[13] = 16'h3444; // MUL R4,R4,R4
    img[14] = 16'h23F1; // SUB R3,(R7),R1
    img[15] = 16'h5000; // NOP
    img[16] = 16'h8F00; // OUT (R7)
    img[17] = 16'h1A6F; // ADD (R2),R6,(R7)
    img[18] = 16'h8A00; // OUT (R2)
    img[19] = 16'hF000; // STOP
  endtask

  function automatic logic [15:0] opv(input logic [3:0] f);
    logic [15:0] p;
    p = mm[{3'b0, f[2:0]}];
    return f[3] ? mm[p[5:0]] : p;
  endfunction

  function automatic logic [5:0] dst(input logic [3:0] f);
    logic [15:0] p;
    p = mm[{3'b0, f[2:0]}];
    return f[3] ? p[5:0] : {3'b0, f[2:0]};
  endfunction

  task automatic run_model();
    logic [15:0] ir, y, z, r;
    logic [5:0] xa;
    logic wr, halted;
    mm = img;
    model_pc = 6'd8;
    halted = 1'b0;
    for (int s = 0; s < 64 && !halted; s++) begin
      ir = mm[model_pc];
      model_pc = model_pc + 6'd1;
      y = opv(ir[7:4]);
      z = opv(ir[3:0]);
      xa = dst(ir[11:8]);
      wr = 1'b1;
      r = y;
      case (ir[15:12])
        4'h0: r = y;
        4'h1: r = y + z;
        4'h2: r = y - z;
        4'h3: r = y * z;
        4'h4: begin wr = z != 16'h0; r = wr ? y / z : y; end
        4'h7: r = in_p;
        4'h8: begin wr = 1'b0; exp_o.push_back(opv(ir[11:8])); end
        4'hF: begin wr = 1'b0; halted = 1'b1; end
        default: wr = 1'b0;
      endcase
      if (wr) begin
        mm[xa] = r;
        exp_w.push_back(wr_t'{a: xa, d: r});
      end
    end
  endtask

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] req);
    ncmp++;
    if (act !== req) begin
      nfail++;
      $display("FAIL %s: got %h, required %h", nm, act, req);
    end
  endtask

  task automatic step();
    wr_t e;
    logic [15:0] eo;
    @(negedge clk);
    if (chk && we) begin
      ncmp++;
      if (exp_w.size() == 0) begin
        nfail++;
        $display("FAIL write_extra: got addr=%0d data=%h, required no write", addr, data);
      end else begin
        e = exp_w.pop_front();
        if (addr !== e.a || data !== e.d) begin
          nfail++;
          $display("FAIL write: got addr=%0d data=%h, required addr=%0d data=%h", addr, data, e.a, e.d);
        end
      end
    end
    if (chk && out_p !== prev_out) begin
      ncmp++;
      if (exp_o.size() == 0) begin
        nfail++;
        $display("FAIL out_extra: got %h, required %h", out_p, prev_out);
      end else begin
        eo = exp_o.pop_front();
        if (out_p !== eo) begin
          nfail++;
          $display("FAIL out: got %h, required %h", out_p, eo);
        end
      end
      prev_out = out_p;
    end
  endtask

  initial begin
    int n;
    build();
    run_model();
    check("model_writes", exp_w.size(), 6);
    check("model_outs", exp_o.size(), 3);
    check("model_pc", {26'b0, model_pc}, 20);
    ld = 1'b1;
    repeat (3) @(negedge clk);
    ld = 1'b0;
    check("rst_pc", {26'b0, pc}, 8);
    check("rst_sp", {26'b0, sp}, 63);
    check("rst_we", {31'b0, we}, 0);
    check("rst_out", {16'b0, out_p}, 0);
    check("rst_addr", {26'b0, addr}, 0);
    check("rst_data", {16'b0, data}, 0);
    rst_n = 1'b1;
    prev_out = out_p;
    chk = 1'b1;
    repeat (300) step();
    check("writes_pending", exp_w.size(), 0);
    check("outs_pending", exp_o.size(), 0);
    check("stop_pc", {26'b0, pc}, 20);
    check("in_r0", {16'b0, m[0]}, 16'h0008);
    check("add_r1", {16'b0, m[1]}, 16'h0010);
    check("sub_r3", {16'b0, m[3]}, 16'h1224);
    check("mul_wrap_r4", {16'b0, m[4]}, 16'h0000);
    check("ind_dest_m5", {16'b0, m[5]}, 16'h123B);
    check("div0_r6", {16'b0, m[6]}, 16'h0007);
    repeat (100) step();
    check("halt_pc", {26'b0, pc}, 20);
    check("halt_out", {16'b0, out_p}, 16'h123B);
    chk = 1'b0;
    rst_n = 1'b0;
    ld = 1'b1;
    repeat (3) @(negedge clk);
    ld = 1'b0;
    rst_n = 1'b1;
    n = 0;
    while (out_p !== 16'h1234 && n < 300) begin
      @(negedge clk);
      n++;
    end
    check("reach_out_1234", {31'b0, n < 300}, 1);
    repeat (6) @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    check("midrst_pc", {26'b0, pc}, 8);
    check("midrst_sp", {26'b0, sp}, 63);
    check("midrst_we", {31'b0, we}, 0);
    check("midrst_addr", {26'b0, addr}, 0);
    check("midrst_data", {16'b0, data}, 0);
    check("midrst_out", {16'b0, out_p}, 0);
    repeat (20) @(negedge clk);
    check("no_write_after_rst", {16'b0, m[5]}, 16'h0010);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", ncmp, nfail);
    $finish;
  end
endmodule
